sum_one_gen: RTL

- Inverse companion of the SPI execution unit's ones-counter: accepts a ones-count and regenerates a canonical 2*NUM-bit operand pair containing exactly that many ones.
- Presents the pair in parallel and shifts it out serially, MSB first, one bit per SPI bit strobe.
- Sits between the exe-unit result path and the SPI shift stage.
- Round-trip rule: counting the ones of {o_a, o_b} returns min(i_cnt, 2*NUM).

---
 rtl/sum_one_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sum_one_gen.sv
// sum_one_gen: turns a ones-count into a 2*NUM-bit thermometer word
// {o_a, o_b} with that many ones set from bit 0 upward. The word is
// presented in parallel and shifted out MSB first, one bit per i_bit_en.
module sum_one_gen #(
  parameter  int NUM = 2,
  localparam int CW  = $clog2(2*NUM+1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [CW-1:0]  i_cnt,
  input  logic           i_bit_en,
  output logic           o_sdo,
  output logic [NUM-1:0] o_a,
  output logic [NUM-1:0] o_b,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err
);

  localparam int            W     = 2*NUM;
  localparam logic [CW-1:0] W_CNT = CW'(W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    word_q, word_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Clamped count and the thermometer mask built one bit wider than the
  // word, so that n = W still yields all ones after truncation.
  logic [CW-1:0]   n_clamped;
  logic            over_range;
  logic [W:0]      mask_wide;
  logic [W-1:0]    mask;

  // Clamp the request and build the n-LSBs-set mask.
  always_comb begin
    over_range = (i_cnt > W_CNT);
    n_clamped  = over_range ? W_CNT : i_cnt;
    mask_wide  = ((W+1)'(1) << n_clamped) - (W+1)'(1);
    mask       = mask_wide[W-1:0];
  end

  // Next-state and next-output computation for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    shift_d = shift_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          word_d  = mask;
          shift_d = mask;
          bcnt_d  = W_CNT;
          err_d   = over_range;
          state_d = ST_SHIFT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_SHIFT: begin
        // i_valid is deliberately ignored here; only the strobe advances.
        if (i_bit_en) begin
          shift_d = {shift_q[W-2:0], 1'b0};
          bcnt_d  = bcnt_q - CW'(1);
          if (bcnt_q == CW'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset overrides everything, even mid-transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      shift_q <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Serial output is only driven while shifting.
  always_comb begin
    o_sdo = (state_q == ST_SHIFT) ? shift_q[W-1] : 1'b0;
  end

  assign o_a     = word_q[W-1:NUM];
  assign o_b     = word_q[NUM-1:0];
  assign o_err   = err_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
